// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word requests to instruction memory and
// presents one instruction per cycle to decode, with redirect and stall
// handling through a one-entry hold buffer.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);

    localparam int unsigned XLEN    = 32;
    localparam logic [31:0] ALIGN_M = ~32'h0000_0003;
    localparam logic [31:0] PC_STEP = 32'h0000_0004;
    localparam logic [31:0] RST_PC  = RESET_PC & ALIGN_M;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   buf_inst_q, buf_inst_d;
    logic [XLEN-1:0]   buf_pc_q,   buf_pc_d;
    logic [XLEN-1:0]   pc_out_q,   pc_out_d;
    logic [XLEN-1:0]   inst_q,     inst_d;
    logic              valid_q,    valid_d;

    logic [XLEN-1:0]   branch_tgt;
    logic              take_branch;

    // Redirects are only honoured when the IF/ID boundary is not stalled
    assign branch_tgt  = branch_addr_i & ALIGN_M;
    assign take_branch = branch_i & ~stall_i;

    // Next-state, next-PC and IF/ID output computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        pc_out_d   = pc_out_q;
        inst_d     = inst_q;
        valid_d    = valid_q;

        unique case (state_q)
            FETCH: begin
                if (mem_ack_i) begin
                    if (take_branch) begin
                        // Returned word is on the wrong path
                        pc_d       = branch_tgt;
                        req_addr_d = branch_tgt;
                        inst_d     = NOP_INST;
                        valid_d    = 1'b0;
                    end else if (stall_i) begin
                        // Park the word until decode can accept it
                        buf_inst_d = mem_rdata_i;
                        buf_pc_d   = req_addr_q;
                        state_d    = HOLD;
                    end else begin
                        pc_out_d   = req_addr_q;
                        inst_d     = mem_rdata_i;
                        valid_d    = 1'b1;
                        pc_d       = req_addr_q + PC_STEP;
                        req_addr_d = req_addr_q + PC_STEP;
                    end
                end else if (take_branch) begin
                    // Request in flight cannot be withdrawn; drain it first
                    pc_d    = branch_tgt;
                    state_d = DISCARD;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
            end

            DISCARD: begin
                if (take_branch) begin
                    pc_d = branch_tgt;
                end
                if (!stall_i) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
                if (mem_ack_i) begin
                    req_addr_d = take_branch ? branch_tgt : pc_q;
                    state_d    = FETCH;
                end
            end

            HOLD: begin
                if (!stall_i) begin
                    state_d = FETCH;
                    if (take_branch) begin
                        pc_d       = branch_tgt;
                        req_addr_d = branch_tgt;
                        inst_d     = NOP_INST;
                        valid_d    = 1'b0;
                    end else begin
                        pc_out_d   = buf_pc_q;
                        inst_d     = buf_inst_q;
                        valid_d    = 1'b1;
                        pc_d       = buf_pc_q + PC_STEP;
                        req_addr_d = buf_pc_q + PC_STEP;
                    end
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RST_PC;
            req_addr_q <= RST_PC;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
            pc_out_q   <= '0;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            pc_out_q   <= pc_out_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    // Outputs are forced to their idle values for as long as rst is held
    assign mem_req_o    = ~rst & ((state_q == FETCH) | (state_q == DISCARD));
    assign mem_addr_o   = rst ? '0 : req_addr_q;
    assign pc_o         = rst ? '0 : pc_out_q;
    assign inst_o       = rst ? NOP_INST : inst_q;
    assign inst_valid_o = ~rst & valid_q;
    assign stallreq_o   = ~rst & (((state_q == FETCH) & ~mem_ack_i) | (state_q == DISCARD));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a delivery scoreboard.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_q[$];
    logic [31:0] s_addr;
    logic        s_req;
    logic        s_stallreq;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .stallreq_o    (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a);
        sb_q.push_back({a, mem_word(a)});
    endtask

    // One clock of stimulus; records request-side outputs seen during the cycle
    // and scores any fresh delivery after the edge.
    task automatic step(input logic ack, input logic stall, input logic br, input logic [31:0] baddr);
        logic [63:0] e;
        mem_ack_i     = ack;
        stall_i       = stall;
        branch_i      = br;
        branch_addr_i = baddr;
        mem_rdata_i   = ack ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;
        #1;
        s_addr     = mem_addr_o;
        s_req      = mem_req_o;
        s_stallreq = stallreq_o;
        @(posedge clk);
        #1;
        if (!stall && inst_valid_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'(inst_valid_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("deliver_pc", pc_o, e[63:32]);
                chk("deliver_inst", inst_o, e[31:0]);
            end
        end
        mem_ack_i = 1'b0;
        stall_i   = 1'b0;
        branch_i  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = '0;

        // Reset values
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_stallreq", 32'(stallreq_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(mem_req_o), 32'd1);
        chk("post_rst_addr", mem_addr_o, 32'h0);
        chk("post_rst_stallreq", 32'(stallreq_o), 32'd1);

        // Back-to-back acks: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            exp_push(32'(4 * i));
            step(1'b1, 1'b0, 1'b0, 32'h0);
            chk("b2b_addr", s_addr, 32'(4 * i));
        end

        // Three-cycle memory latency at 0x10
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("lat_addr0", s_addr, 32'h10);
        chk("lat_stall0", 32'(s_stallreq), 32'd1);
        chk("lat_bubble_valid", 32'(inst_valid_o), 32'd0);
        chk("lat_bubble_inst", inst_o, NOP);
        chk("lat_bubble_pc", pc_o, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("lat_addr1", s_addr, 32'h10);
        chk("lat_stall1", 32'(s_stallreq), 32'd1);
        exp_push(32'h10);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("lat_addr2", s_addr, 32'h10);
        chk("lat_stall2", 32'(s_stallreq), 32'd0);

        // Advance to 0x20, then redirect while that request is outstanding
        for (int i = 0; i < 3; i++) begin
            exp_push(32'(32'h14 + 4 * i));
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 1'b1, 32'h100);
        chk("br_pending_addr", s_addr, 32'h20);
        chk("br_bubble_valid", 32'(inst_valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("discard_addr", s_addr, 32'h20);
        chk("discard_stallreq", 32'(s_stallreq), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("discard_ack_addr", s_addr, 32'h20);
        exp_push(32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("br_target_addr", s_addr, 32'h100);

        // Branch on the ack cycle: data dropped, next request at the target
        step(1'b1, 1'b0, 1'b1, 32'h200);
        chk("ackbr_valid", 32'(inst_valid_o), 32'd0);
        chk("ackbr_inst", inst_o, NOP);
        exp_push(32'h200);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("ackbr_target_addr", s_addr, 32'h200);

        // Ack for 0x40 under a two-cycle stall
        step(1'b1, 1'b0, 1'b1, 32'h40);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold_ack_addr", s_addr, 32'h40);
        chk("hold_frozen_pc0", pc_o, 32'h200);
        chk("hold_frozen_valid0", 32'(inst_valid_o), 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h300);
        chk("hold_req", 32'(s_req), 32'd0);
        chk("hold_frozen_pc1", pc_o, 32'h200);
        chk("hold_frozen_inst1", inst_o, NOP);
        exp_push(32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("hold_release_req", 32'(s_req), 32'd0);
        exp_push(32'h44);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("hold_next_addr", s_addr, 32'h44);

        // PC wrap and branch target alignment
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        exp_push(32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b1, 32'h103);
        chk("wrap_zero_addr", s_addr, 32'h0);
        exp_push(32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("align_addr", s_addr, 32'h100);

        // Branch taken out of HOLD drops the buffered word
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h80);
        chk("holdbr_valid", 32'(inst_valid_o), 32'd0);
        chk("holdbr_pc", pc_o, 32'h100);

        // Reset while in DISCARD abandons the transaction
        step(1'b0, 1'b0, 1'b1, 32'h500);
        chk("holdbr_target_addr", s_addr, 32'h80);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_disc_req_during", 32'(s_req), 32'd0);
        chk("rst_disc_stallreq_during", 32'(s_stallreq), 32'd0);
        chk("rst_disc_pc", pc_o, 32'h0);
        chk("rst_disc_inst", inst_o, NOP);
        chk("rst_disc_valid", 32'(inst_valid_o), 32'd0);
        rst = 1'b0;
        exp_push(32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_disc_first_addr", s_addr, 32'h0);
        exp_push(32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_disc_second_addr", s_addr, 32'h4);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
